// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ttt_game_ctrl
// Purpose  : Synchronous game sequencer for a 3x3 tic-tac-toe board. Turns
//            raw cell buttons into single moves, arbitrates simultaneous
//            presses, enforces turn order, rejects occupied cells, detects
//            win/draw, keeps a saturating score and auto-clears the board
//            after a result hold period.
// Ports    : clk, reset (sync, active-high)
//            i_button[8:0]      raw cell buttons, bit0=a .. bit8=i (row-major)
//            o_p1_cells/o_p2_cells  registered cell ownership masks
//            o_turn_p1/o_turn_p2    side to move
//            o_move_valid/o_move_reject  one-cycle move outcome pulses
//            o_p1_win/o_p2_win/o_draw   round result, held through DONE
//            o_busy             high while not accepting moves
//            o_p1_score/o_p2_score  saturating round-win counters
// Revision : 1.0 - initial release
// ============================================================================
module ttt_game_ctrl #(
  parameter int RESULT_HOLD = 16,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         i_button,
  output logic [8:0]         o_p1_cells,
  output logic [8:0]         o_p2_cells,
  output logic               o_turn_p1,
  output logic               o_turn_p2,
  output logic               o_move_valid,
  output logic               o_move_reject,
  output logic               o_p1_win,
  output logic               o_p2_win,
  output logic               o_draw,
  output logic               o_busy,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam int                  c_HOLD_W    = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESULT_HOLD - 1);
  localparam logic [SCORE_W-1:0]  c_SCORE_MAX = {SCORE_W{1'b1}};

  state_t              r_state;
  logic [8:0]          r_button_q;
  logic [8:0]          r_p1_cells;
  logic [8:0]          r_p2_cells;
  logic                r_turn_p1;
  logic                r_starter_p1;
  logic                r_move_valid;
  logic                r_move_reject;
  logic                r_p1_win;
  logic                r_p2_win;
  logic                r_draw;
  logic [SCORE_W-1:0]  r_p1_score;
  logic [SCORE_W-1:0]  r_p2_score;
  logic [c_HOLD_W-1:0] r_hold;

  logic [8:0] w_press;
  logic [8:0] w_pick;
  logic [8:0] w_occupied;
  logic [8:0] w_mover;
  logic       w_mover_win;
  logic       w_full;

  // Any of the eight lines fully owned by mask m.
  function automatic logic f_win(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  assign w_press     = i_button & ~r_button_q;
  // Two's-complement trick isolates the lowest set bit: lowest index wins.
  assign w_pick      = w_press & (~w_press + 9'd1);
  assign w_occupied  = r_p1_cells | r_p2_cells;
  // Turn has not toggled yet in CHECK, so the side to move is the mover.
  assign w_mover     = r_turn_p1 ? r_p1_cells : r_p2_cells;
  assign w_mover_win = f_win(w_mover);
  assign w_full      = &w_occupied;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_PLAY;
      r_button_q    <= '0;
      r_p1_cells    <= '0;
      r_p2_cells    <= '0;
      r_turn_p1     <= 1'b1;
      r_starter_p1  <= 1'b1;
      r_move_valid  <= 1'b0;
      r_move_reject <= 1'b0;
      r_p1_win      <= 1'b0;
      r_p2_win      <= 1'b0;
      r_draw        <= 1'b0;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_hold        <= '0;
    end else begin
      // Sampled in every state so presses outside PLAY are consumed.
      r_button_q    <= i_button;
      r_move_valid  <= 1'b0;
      r_move_reject <= 1'b0;

      case (r_state)
        S_PLAY: begin
          if (|w_pick) begin
            if (|(w_pick & w_occupied)) begin
              r_move_reject <= 1'b1;
            end else begin
              if (r_turn_p1) r_p1_cells <= r_p1_cells | w_pick;
              else           r_p2_cells <= r_p2_cells | w_pick;
              r_move_valid <= 1'b1;
              r_state      <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          r_hold <= '0;
          if (w_mover_win) begin
            // A winning ninth move counts as a win, never a draw.
            if (r_turn_p1) begin
              r_p1_win <= 1'b1;
              if (r_p1_score != c_SCORE_MAX) r_p1_score <= r_p1_score + SCORE_W'(1);
            end else begin
              r_p2_win <= 1'b1;
              if (r_p2_score != c_SCORE_MAX) r_p2_score <= r_p2_score + SCORE_W'(1);
            end
            r_state <= S_DONE;
          end else if (w_full) begin
            r_draw  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_turn_p1 <= ~r_turn_p1;
            r_state   <= S_PLAY;
          end
        end

        S_DONE: begin
          if (r_hold == c_HOLD_LAST) r_state <= S_CLEAR;
          else                       r_hold  <= r_hold + c_HOLD_W'(1);
        end

        S_CLEAR: begin
          r_p1_cells   <= '0;
          r_p2_cells   <= '0;
          r_p1_win     <= 1'b0;
          r_p2_win     <= 1'b0;
          r_draw       <= 1'b0;
          r_hold       <= '0;
          r_starter_p1 <= ~r_starter_p1;
          r_turn_p1    <= ~r_starter_p1;
          r_state      <= S_PLAY;
        end

        default: r_state <= S_PLAY;
      endcase
    end
  end

  assign o_p1_cells    = r_p1_cells;
  assign o_p2_cells    = r_p2_cells;
  assign o_turn_p1     = r_turn_p1;
  assign o_turn_p2     = ~r_turn_p1;
  assign o_move_valid  = r_move_valid;
  assign o_move_reject = r_move_reject;
  assign o_p1_win      = r_p1_win;
  assign o_p2_win      = r_p2_win;
  assign o_draw        = r_draw;
  assign o_busy        = (r_state != S_PLAY);
  assign o_p1_score    = r_p1_score;
  assign o_p2_score    = r_p2_score;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttt_game_ctrl
// Purpose  : Directed self-checking bench for ttt_game_ctrl. Inputs change on
//            the falling edge, outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttt_game_ctrl;

  localparam int RESULT_HOLD = 4;
  localparam int SCORE_W     = 2;

  logic               clk;
  logic               reset;
  logic [8:0]         i_button;
  logic [8:0]         o_p1_cells;
  logic [8:0]         o_p2_cells;
  logic               o_turn_p1;
  logic               o_turn_p2;
  logic               o_move_valid;
  logic               o_move_reject;
  logic               o_p1_win;
  logic               o_p2_win;
  logic               o_draw;
  logic               o_busy;
  logic [SCORE_W-1:0] o_p1_score;
  logic [SCORE_W-1:0] o_p2_score;

  int n_total = 0;
  int n_pass  = 0;

  ttt_game_ctrl #(
    .RESULT_HOLD(RESULT_HOLD),
    .SCORE_W    (SCORE_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_button     (i_button),
    .o_p1_cells   (o_p1_cells),
    .o_p2_cells   (o_p2_cells),
    .o_turn_p1    (o_turn_p1),
    .o_turn_p2    (o_turn_p2),
    .o_move_valid (o_move_valid),
    .o_move_reject(o_move_reject),
    .o_p1_win     (o_p1_win),
    .o_p2_win     (o_p2_win),
    .o_draw       (o_draw),
    .o_busy       (o_busy),
    .o_p1_score   (o_p1_score),
    .o_p2_score   (o_p2_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell indices, row-major.
  localparam int A = 0, B = 1, C = 2, D = 3, E = 4, F = 5, G = 6, H = 7, I = 8;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive a button pattern for one cycle, release it, and return at the
  // falling edge where CHECK results (flags or turn toggle) are visible.
  task automatic press_vec(input logic [8:0] b, output logic mv, output logic mr);
    @(negedge clk);
    i_button = b;
    @(negedge clk);
    mv = o_move_valid;
    mr = o_move_reject;
    i_button = '0;
    @(negedge clk);
  endtask

  task automatic move(input int k);
    logic mv, mr;
    logic [8:0] b;
    b = 9'd1 << k;
    press_vec(b, mv, mr);
    check_eq($sformatf("move_valid cell %0d", k), {31'd0, mv}, 32'd1);
  endtask

  // Step from the first DONE cycle through CLEAR into the next PLAY cycle.
  task automatic wait_clear();
    repeat (RESULT_HOLD + 1) @(negedge clk);
  endtask

  // P1 takes a,b,c. Opponent takes d,e (and g when P2 opened the round).
  task automatic round_p1_win(input logic p2_first);
    if (p2_first) begin
      move(D); move(A); move(E); move(B); move(G); move(C);
    end else begin
      move(A); move(D); move(B); move(E); move(C);
    end
  endtask

  initial begin
    logic mv, mr;
    reset    = 1'b1;
    i_button = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst p1_cells", {23'd0, o_p1_cells}, 32'd0);
    check_eq("rst p2_cells", {23'd0, o_p2_cells}, 32'd0);
    check_eq("rst turn_p1",  {31'd0, o_turn_p1},  32'd1);
    check_eq("rst turn_p2",  {31'd0, o_turn_p2},  32'd0);
    check_eq("rst busy",     {31'd0, o_busy},     32'd0);
    check_eq("rst flags",    {29'd0, o_p1_win, o_p2_win, o_draw}, 32'd0);
    check_eq("rst scores",   {28'd0, o_p1_score, o_p2_score}, 32'd0);

    // Round 1: P1 wins on the top row
    move(A);
    check_eq("turn after a", {31'd0, o_turn_p2}, 32'd1);
    move(D); move(B); move(E);
    check_eq("no early win", {31'd0, o_p1_win}, 32'd0);
    move(C);
    check_eq("r1 p1_win",   {31'd0, o_p1_win},    32'd1);
    check_eq("r1 draw",     {31'd0, o_draw},      32'd0);
    check_eq("r1 p1_cells", {23'd0, o_p1_cells},  32'h007);
    check_eq("r1 p2_cells", {23'd0, o_p2_cells},  32'h018);
    check_eq("r1 p1_score", {30'd0, o_p1_score},  32'd1);
    for (int n = 0; n <= RESULT_HOLD; n++) begin
      check_eq($sformatf("r1 busy %0d", n), {31'd0, o_busy}, 32'd1);
      @(negedge clk);
    end
    check_eq("r1 cleared cells", {14'd0, o_p1_cells, o_p2_cells}, 32'd0);
    check_eq("r1 cleared flag",  {31'd0, o_p1_win}, 32'd0);
    check_eq("r1 busy low",      {31'd0, o_busy},   32'd0);
    check_eq("r2 starter p2",    {31'd0, o_turn_p2}, 32'd1);

    // Round 2: simultaneous c+e from P2, only c is taken
    press_vec(9'b000010100, mv, mr);
    check_eq("arb move_valid", {31'd0, mv}, 32'd1);
    check_eq("arb p2_cells",   {23'd0, o_p2_cells}, 32'h004);
    move(E);
    check_eq("e was free",     {23'd0, o_p1_cells}, 32'h010);

    // P2 presses e, now owned by P1: one reject pulse, nothing changes
    @(negedge clk);
    i_button = 9'd1 << E;
    @(negedge clk);
    check_eq("rej pulse",      {31'd0, o_move_reject}, 32'd1);
    check_eq("rej no valid",   {31'd0, o_move_valid},  32'd0);
    @(negedge clk);
    check_eq("rej one cycle",  {31'd0, o_move_reject}, 32'd0);
    @(negedge clk);
    check_eq("rej held",       {31'd0, o_move_reject}, 32'd0);
    i_button = '0;
    check_eq("rej masks",      {14'd0, o_p1_cells, o_p2_cells}, {14'd0, 9'h010, 9'h004});
    check_eq("rej turn",       {31'd0, o_turn_p2}, 32'd1);

    // P2 completes a,b,c
    move(A); move(D); move(B);
    check_eq("r2 p2_win",   {31'd0, o_p2_win},   32'd1);
    check_eq("r2 p2_score", {30'd0, o_p2_score}, 32'd1);
    wait_clear();

    // Round 3: draw
    move(A); move(B); move(C); move(D); move(F);
    move(E); move(G); move(I); move(H);
    check_eq("r3 draw",    {31'd0, o_draw},   32'd1);
    check_eq("r3 no win",  {30'd0, o_p1_win, o_p2_win}, 32'd0);
    check_eq("r3 scores",  {28'd0, o_p1_score, o_p2_score}, 32'b0101);
    wait_clear();
    check_eq("r3 cleared", {14'd0, o_p1_cells, o_p2_cells}, 32'd0);
    check_eq("r4 starter p2", {31'd0, o_turn_p2}, 32'd1);

    // Round 4: P2 wins with the ninth move (full board)
    move(A); move(B); move(C); move(D); move(H);
    move(F); move(E); move(G); move(I);
    check_eq("r4 p2_win",   {31'd0, o_p2_win},   32'd1);
    check_eq("r4 no draw",  {31'd0, o_draw},     32'd0);
    check_eq("r4 p2_score", {30'd0, o_p2_score}, 32'd2);
    wait_clear();

    // Rounds 5-7: P1 wins repeatedly, score saturates at 3
    round_p1_win(1'b0);
    check_eq("r5 p1_score", {30'd0, o_p1_score}, 32'd2);
    wait_clear();
    round_p1_win(1'b1);
    check_eq("r6 p1_score", {30'd0, o_p1_score}, 32'd3);
    wait_clear();
    round_p1_win(1'b0);
    check_eq("r7 p1 saturated", {30'd0, o_p1_score}, 32'd3);
    check_eq("r7 p1_win",       {31'd0, o_p1_win},   32'd1);

    // Reset in the middle of DONE
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid rst scores", {28'd0, o_p1_score, o_p2_score}, 32'd0);
    check_eq("mid rst cells",  {14'd0, o_p1_cells, o_p2_cells}, 32'd0);
    check_eq("mid rst busy",   {31'd0, o_busy},    32'd0);
    check_eq("mid rst turn",   {31'd0, o_turn_p1}, 32'd1);
    check_eq("mid rst flags",  {29'd0, o_p1_win, o_p2_win, o_draw}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
